alu_operand_stage: RTL and testbench

Operand-fetch stage directly upstream of the ALU. Holds the architectural register file (one write port, two read ports) and a single valid/ready pipeline register. It captures an issued operation, resolves its operands from the register file, the same-cycle writeback bypass or an immediate, and presents registered `a`, `b` and `op_sel` to the ALU. Writebacks that arrive while the stage is stalled keep the held operands current.

---
 rtl/alu_operand_stage.sv | 158 +++++++++++++++
 tb/tb_alu_operand_stage.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// Operand-fetch stage in front of the ALU. Holds the architectural register
// file (one write port, two read ports) and a single valid/ready pipeline
// register that presents registered operands a/b and op_sel to the ALU.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid / in_ready     upstream handshake (in_ready is combinational)
//   rs_addr, rt_addr        source registers for operands a and b
//   imm, use_imm            immediate and its select for operand b
//   op_sel_in               ALU operation code, passed through
//   wb_en, wb_addr, wb_data register-file writeback port
//   out_valid / out_ready   downstream handshake
//   a, b, op_sel            registered operands and operation code
module alu_operand_stage #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    input  logic [DATA_WIDTH-1:0] imm,
    input  logic                  use_imm,
    input  logic [2:0]            op_sel_in,
    input  logic                  wb_en,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] b,
    output logic [2:0]            op_sel
);

    localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;
    localparam int unsigned OP_WIDTH = 3;

    // Register file; entry 0 is never written so it always reads as zero.
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Held operation context used for stall refresh.
    logic [ADDR_WIDTH-1:0] hold_rs;
    logic [ADDR_WIDTH-1:0] hold_rt;
    logic                  hold_use_imm;

    // Next-state values for the pipeline register.
    logic [DATA_WIDTH-1:0] a_d;
    logic [DATA_WIDTH-1:0] b_d;
    logic [OP_WIDTH-1:0]   op_sel_d;
    logic [ADDR_WIDTH-1:0] hold_rs_d;
    logic [ADDR_WIDTH-1:0] hold_rt_d;
    logic                  hold_use_imm_d;
    logic                  out_valid_d;

    logic                  accept;
    logic                  transfer;
    logic                  stall;
    logic                  wb_live;
    logic [DATA_WIDTH-1:0] rs_val;
    logic [DATA_WIDTH-1:0] rt_val;

    // Handshake qualifiers.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign transfer = out_valid && out_ready;
    assign stall    = out_valid && !out_ready;
    assign wb_live  = wb_en && (wb_addr != '0);

    // Register file write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Operand a read with same-cycle writeback bypass; address 0 forced to zero.
    always_comb begin
        rs_val = regs[rs_addr];
        if (rs_addr == '0) begin
            rs_val = '0;
        end else if (wb_en && (wb_addr == rs_addr)) begin
            rs_val = wb_data;
        end
    end

    // Operand b register read, same rule as operand a.
    always_comb begin
        rt_val = regs[rt_addr];
        if (rt_addr == '0) begin
            rt_val = '0;
        end else if (wb_en && (wb_addr == rt_addr)) begin
            rt_val = wb_data;
        end
    end

    // Pipeline register next state: capture on accept, refresh on stall.
    always_comb begin
        a_d            = a;
        b_d            = b;
        op_sel_d       = op_sel;
        hold_rs_d      = hold_rs;
        hold_rt_d      = hold_rt;
        hold_use_imm_d = hold_use_imm;
        out_valid_d    = out_valid;

        if (accept) begin
            a_d            = rs_val;
            b_d            = use_imm ? imm : rt_val;
            op_sel_d       = op_sel_in;
            hold_rs_d      = rs_addr;
            hold_rt_d      = rt_addr;
            hold_use_imm_d = use_imm;
            out_valid_d    = 1'b1;
        end else begin
            if (transfer) begin
                out_valid_d = 1'b0;
            end
            // Held operands track writebacks so the ALU never sees stale data.
            if (stall && wb_live) begin
                if (wb_addr == hold_rs) begin
                    a_d = wb_data;
                end
                if (!hold_use_imm && (wb_addr == hold_rt)) begin
                    b_d = wb_data;
                end
            end
        end
    end

    // Pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a            <= '0;
            b            <= '0;
            op_sel       <= '0;
            hold_rs      <= '0;
            hold_rt      <= '0;
            hold_use_imm <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            a            <= a_d;
            b            <= b_d;
            op_sel       <= op_sel_d;
            hold_rs      <= hold_rs_d;
            hold_rt      <= hold_rt_d;
            hold_use_imm <= hold_use_imm_d;
            out_valid    <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Testbench for alu_operand_stage: scoreboard of expected operands pushed on
// accept and popped when the stage transfers to the ALU side.
module tb_alu_operand_stage;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 3;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] rs_addr;
    logic [AW-1:0] rt_addr;
    logic [DW-1:0] imm;
    logic          use_imm;
    logic [2:0]    op_sel_in;
    logic          wb_en;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [2:0]    op_sel;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [2:0]    op;
        logic [AW-1:0] rs;
        logic [AW-1:0] rt;
        logic          ui;
    } exp_t;

    exp_t          q[$];
    logic [DW-1:0] mdl [2**AW];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            n_pops   = 0;

    alu_operand_stage #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs_addr   (rs_addr),
        .rt_addr   (rt_addr),
        .imm       (imm),
        .use_imm   (use_imm),
        .op_sel_in (op_sel_in),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .b         (b),
        .op_sel    (op_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard: every transfer must match the oldest expected operation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            exp_t e;
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: transfer with empty scoreboard a=%h b=%h op=%0d", a, b, op_sel);
            end else begin
                e = q.pop_front();
                n_pops++;
                if (a !== e.a || b !== e.b || op_sel !== e.op) begin
                    n_fail++;
                    $display("FAIL sb_data: got a=%h b=%h op=%0d, expected a=%h b=%h op=%0d",
                             a, b, op_sel, e.a, e.b, e.op);
                end
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < 2**AW; i++) mdl[i] = '0;
        q.delete();
    endtask

    // One-cycle writeback; mirrors stall refresh onto the held expectation.
    task automatic wb_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        exp_t e;
        wb_en   = 1'b1;
        wb_addr = addr;
        wb_data = data;
        if (q.size() > 0 && !out_ready && addr != '0) begin
            e = q[0];
            if (e.rs == addr) e.a = data;
            if (!e.ui && e.rt == addr) e.b = data;
            q[0] = e;
        end
        if (addr != '0) mdl[addr] = data;
        @(posedge clk); #1;
        wb_en = 1'b0;
    endtask

    // Offer one operation (optionally with a concurrent writeback) until accepted.
    task automatic issue(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                         input logic [DW-1:0] imm_v, input logic ui, input logic [2:0] op,
                         input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        exp_t e;
        int   n;
        rs_addr   = rs;
        rt_addr   = rt;
        imm       = imm_v;
        use_imm   = ui;
        op_sel_in = op;
        wb_en     = we;
        wb_addr   = wa;
        wb_data   = wd;
        in_valid  = 1'b1;
        e.rs = rs;
        e.rt = rt;
        e.ui = ui;
        e.op = op;
        if (rs == '0)                 e.a = '0;
        else if (we && wa == rs)      e.a = wd;
        else                          e.a = mdl[rs];
        if (ui)                       e.b = imm_v;
        else if (rt == '0)            e.b = '0;
        else if (we && wa == rt)      e.b = wd;
        else                          e.b = mdl[rt];
        if (we && wa != '0) mdl[wa] = wd;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: in_ready=%b, expected 1 within 50 cycles", in_ready);
        end else begin
            q.push_back(e);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        wb_en    = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (q.size() > 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || a !== '0 || b !== '0 || op_sel !== '0) begin
            n_fail++;
            $display("FAIL reset_state: out_valid=%b in_ready=%b a=%h b=%h op=%0d, expected 0 1 00 00 0",
                     out_valid, in_ready, a, b, op_sel);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        out_ready = 1'b1;
        wb_write(3'd3, 8'h2A);
        wb_write(3'd5, 8'h07);
        issue(3'd3, 3'd5, 8'h00, 1'b0, 3'b001, 1'b0, 3'd0, 8'h00);
        n_checks++;
        if (out_valid !== 1'b1 || a !== 8'h2A || b !== 8'h07 || op_sel !== 3'b001) begin
            n_fail++;
            $display("FAIL basic_latency: out_valid=%b a=%h b=%h op=%0d, expected 1 2a 07 1",
                     out_valid, a, b, op_sel);
        end
        drain();
    endtask

    task automatic test_bypass();
        out_ready = 1'b1;
        issue(3'd4, 3'd0, 8'h00, 1'b0, 3'b010, 1'b1, 3'd4, 8'h55);
        n_checks++;
        if (a !== 8'h55) begin
            n_fail++;
            $display("FAIL bypass_a: a=%h, expected 55", a);
        end
        issue(3'd4, 3'd4, 8'h00, 1'b0, 3'b011, 1'b0, 3'd0, 8'h00);
        drain();
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        wb_write(3'd0, 8'hFF);
        issue(3'd0, 3'd0, 8'h00, 1'b0, 3'b100, 1'b0, 3'd0, 8'h00);
        n_checks++;
        if (a !== 8'h00 || b !== 8'h00) begin
            n_fail++;
            $display("FAIL zero_read: a=%h b=%h, expected 00 00", a, b);
        end
        issue(3'd0, 3'd0, 8'h00, 1'b0, 3'b101, 1'b1, 3'd0, 8'hAA);
        n_checks++;
        if (a !== 8'h00 || b !== 8'h00) begin
            n_fail++;
            $display("FAIL zero_bypass: a=%h b=%h, expected 00 00", a, b);
        end
        drain();
    endtask

    task automatic test_imm();
        out_ready = 1'b1;
        wb_write(3'd2, 8'h10);
        issue(3'd2, 3'd6, 8'h0C, 1'b1, 3'b000, 1'b0, 3'd0, 8'h00);
        drain();
        out_ready = 1'b0;
        issue(3'd2, 3'd6, 8'h0C, 1'b1, 3'b000, 1'b0, 3'd0, 8'h00);
        wb_write(3'd6, 8'h77);
        n_checks++;
        if (a !== 8'h10 || b !== 8'h0C || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL imm_stall: out_valid=%b a=%h b=%h, expected 1 10 0c", out_valid, a, b);
        end
        drain();
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        wb_write(3'd1, 8'h01);
        out_ready = 1'b0;
        issue(3'd1, 3'd1, 8'h00, 1'b0, 3'b101, 1'b0, 3'd0, 8'h00);
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_in_ready: in_ready=%b, expected 0", in_ready);
        end
        wb_write(3'd1, 8'h99);
        n_checks++;
        if (a !== 8'h99 || b !== 8'h99 || op_sel !== 3'b101 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_refresh: out_valid=%b a=%h b=%h op=%0d, expected 1 99 99 5",
                     out_valid, a, b, op_sel);
        end
        // Pending issue while stalled, released together with out_ready.
        fork
            issue(3'd3, 3'd5, 8'h00, 1'b0, 3'b110, 1'b0, 3'd0, 8'h00);
            begin
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        n_checks++;
        if (out_valid !== 1'b1 || a !== 8'h2A || b !== 8'h07 || op_sel !== 3'b110) begin
            n_fail++;
            $display("FAIL stall_release: out_valid=%b a=%h b=%h op=%0d, expected 1 2a 07 6",
                     out_valid, a, b, op_sel);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] srcs [4];
        int            p0;
        srcs[0] = 3'd3; srcs[1] = 3'd5; srcs[2] = 3'd2; srcs[3] = 3'd1;
        out_ready = 1'b1;
        p0 = n_pops;
        for (int k = 0; k < 4; k++) begin
            issue(srcs[k], srcs[3-k], 8'h00, 1'b0, 3'(k), 1'b0, 3'd0, 8'h00);
            n_checks++;
            if (out_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_valid_%0d: out_valid=%b, expected 1", k, out_valid);
            end
        end
        drain();
        n_checks++;
        if (n_pops - p0 != 4) begin
            n_fail++;
            $display("FAIL b2b_count: %0d transfers, expected 4", n_pops - p0);
        end
    endtask

    task automatic test_reset_mid_stream();
        out_ready = 1'b1;
        issue(3'd3, 3'd5, 8'h00, 1'b0, 3'b111, 1'b0, 3'd0, 8'h00);
        in_valid  = 1'b1;
        rs_addr   = 3'd2;
        out_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || a !== '0 || b !== '0 || op_sel !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: out_valid=%b in_ready=%b a=%h b=%h op=%0d, expected 0 1 00 00 0",
                     out_valid, in_ready, a, b, op_sel);
        end
        in_valid = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        issue(3'd3, 3'd5, 8'h00, 1'b0, 3'b001, 1'b0, 3'd0, 8'h00);
        n_checks++;
        if (a !== 8'h00 || b !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_regfile: a=%h b=%h, expected 00 00", a, b);
        end
        drain();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        rs_addr   = '0;
        rt_addr   = '0;
        imm       = '0;
        use_imm   = 1'b0;
        op_sel_in = '0;
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        out_ready = 1'b0;
        model_reset();
        test_reset();
        test_basic();
        test_bypass();
        test_zero();
        test_imm();
        test_stall();
        test_back_to_back();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
